mcp_threshold_trainer: RTL and testbench
========================================

// Module: mcp_threshold_trainer
// PURPOSE
//   Drives the MCP neuron input side (x, y, Threshold) and observes its fire output.
//   Given a target 2-input truth table, it sweeps Threshold upward from 0.
//   For each threshold it applies all four input patterns and checks fire against the target.
//   Reports the first threshold that reproduces the table, or reports not-found (e.g. XOR).
//   Sits next to a neuronode instance as its self-training controller.
// PARAMETERS
//   THRESH_W       2  width of Threshold; thresholds 0..2**THRESH_W-1 are tried
//   SETTLE_CYCLES  2  cycles between driving a pattern and sampling fire (0 allowed)
// PORTS
//   clk             in   1         single clock, rising edge
//   rst_n           in   1         asynchronous, active-low reset
//   start           in   1         begin training; sampled only in IDLE
//   target          in   4         expected fire; bit i is for x=i[1], y=i[0]
//   x_out           out  1         neuron input x
//   y_out           out  1         neuron input y
//   thresh_out      out  THRESH_W  neuron Threshold
//   fire_in         in   1         neuron fire output (combinational neuron)
//   busy            out  1         high from start acceptance until DONE
//   done            out  1         one-cycle pulse at end of training
//   found           out  1         a matching threshold exists; held until next start
//   learned_thresh  out  THRESH_W  matching threshold, valid when found; held
//   attempts        out  THRESH_W+1  number of thresholds tried in last run; held
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE; async assert, sync release.
//   FSM states: IDLE -> DRIVE -> WAIT -> CHECK -> (DRIVE | DONE) -> IDLE.
//   IDLE:
//     - On start=1: latch target; clear thresh, idx, attempts, found, learned_thresh.
//     - Set busy=1 and go to DRIVE.
//   DRIVE (1 cycle):
//     - Register x_out=idx[1], y_out=idx[0], thresh_out=thresh.
//     - Go to WAIT, or to CHECK if SETTLE_CYCLES=0.
//   WAIT: count SETTLE_CYCLES cycles, then go to CHECK.
//   CHECK (1 cycle): compare fire_in with target[idx].
//     - Match and idx<3: idx++, go to DRIVE.
//     - Match and idx==3: found=1, learned_thresh=thresh, attempts++, go to DONE.
//     - Mismatch: abort this sweep; attempts++.
//       - If thresh==max: found=0, go to DONE.
//       - Else: thresh++, idx=0, go to DRIVE.
//   DONE (1 cycle): done=1, busy=0 on exit; go to IDLE.
//   Cost: each pattern takes SETTLE_CYCLES+2 cycles.
//   Timing: done rises (patterns_checked x (SETTLE_CYCLES+2)) + 1 cycles after the start edge.
//   start while busy: ignored. start in the DONE cycle: ignored.
//   x_out, y_out, thresh_out hold their last values in IDLE (no glitching to 0).
//   Reset mid-run: immediate return to IDLE; found, learned_thresh, attempts cleared.
//   target changes while busy: ignored, since the latched copy is used.
//   thresh never wraps: max threshold is the final attempt.
// STRUCTURE
//   Shared package mcp_pkg holds:
//     - the state enum;
//     - the default THRESH_W;
//     - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110,
//       TT_ONE=4'b1111, TT_ZERO=4'b0000.
//   No sub-module: the settle counter and pattern index are inline.
//   The bench instantiates neuronode and closes the loop fire -> fire_in.
// TESTING (loop-back to neuronode, SETTLE_CYCLES=2)
//   target=TT_AND -> T=0 fails, T=1 fails, T=2 passes.
//     Expect found=1, learned_thresh=2, attempts=3.
//   target=TT_OR -> T=0 fails at idx0, T=1 passes 4 patterns.
//     Expect found=1, learned_thresh=1, attempts=2, done at cycle 21.
//   target=TT_ONE -> expect found=1, learned_thresh=0, attempts=1, done at cycle 17.
//   target=TT_XOR -> expect found=0, attempts=4, single done pulse.
//   target=TT_ZERO -> expect found=1, learned_thresh=3, attempts=4.
//   Extra start pulses while busy -> no effect on the result.
//   rst_n low mid-run -> all outputs 0 asynchronously; a fresh start then succeeds.

Source files
------------

// File: rtl/mcp_pkg.sv
// -----------------------------------------------------------------------------
// mcp_pkg
//   Shared definitions for the MCP neuron self-training controller.
//   Contents:
//     state_t            trainer FSM state encoding
//     THRESH_W_DEFAULT   default Threshold width
//     TT_*               common 2-input truth tables (bit i <-> x=i[1], y=i[0])
// -----------------------------------------------------------------------------
package mcp_pkg;

  localparam int THRESH_W_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_ONE  = 4'b1111;
  localparam logic [3:0] TT_ZERO = 4'b0000;

endpackage

// File: rtl/neuronode.sv
// -----------------------------------------------------------------------------
// neuronode
//   Combinational McCulloch-Pitts neuron with two unit-weight inputs.
//   Fires when the number of active inputs reaches the threshold.
//   Ports:
//     x, y       in   binary inputs
//     Threshold  in   firing threshold
//     fire       out  1 when x + y >= Threshold
// -----------------------------------------------------------------------------
module neuronode #(
  parameter int THRESH_W = 2
) (
  input  logic                x,
  input  logic                y,
  input  logic [THRESH_W-1:0] Threshold,
  output logic                fire
);

  logic [THRESH_W:0] w_sum;

  assign w_sum = (THRESH_W+1)'(x) + (THRESH_W+1)'(y);
  assign fire  = (w_sum >= {1'b0, Threshold});

endmodule

// File: rtl/mcp_threshold_trainer.sv
// -----------------------------------------------------------------------------
// mcp_threshold_trainer
//   Self-training controller for an MCP neuron. Sweeps Threshold upward from
//   0; for each value it applies all four (x,y) patterns and compares fire
//   with the latched target truth table. Reports the first threshold that
//   reproduces the table, or not-found after the maximum threshold fails.
//   Ports:
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     start           begin training (only honoured in IDLE)
//     target[3:0]     expected fire, bit i for x=i[1], y=i[0]
//     x_out, y_out    neuron inputs
//     thresh_out      neuron Threshold
//     fire_in         neuron fire output (combinational neuron)
//     busy            high from start acceptance until DONE exits
//     done            one-cycle pulse at end of training
//     found           a matching threshold exists (held until next start)
//     learned_thresh  matching threshold (held)
//     attempts        thresholds tried in the last run (held)
// -----------------------------------------------------------------------------
module mcp_threshold_trainer
  import mcp_pkg::*;
#(
  parameter int THRESH_W      = THRESH_W_DEFAULT,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          target,
  output logic                x_out,
  output logic                y_out,
  output logic [THRESH_W-1:0] thresh_out,
  input  logic                fire_in,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [THRESH_W-1:0] learned_thresh,
  output logic [THRESH_W:0]   attempts
);

  // Settle counter is sized for at least one bit so SETTLE_CYCLES=0 still
  // elaborates; WAIT is simply never entered in that case.
  localparam int                CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [THRESH_W-1:0] THRESH_MAX = '1;

  state_t              r_state;
  logic [3:0]          r_target;
  logic [1:0]          r_idx;
  logic [THRESH_W-1:0] r_thresh;
  logic [CNT_W-1:0]    r_settle;
  logic                r_x;
  logic                r_y;
  logic [THRESH_W-1:0] r_thresh_out;
  logic                r_busy;
  logic                r_done;
  logic                r_found;
  logic [THRESH_W-1:0] r_learned;
  logic [THRESH_W:0]   r_attempts;
  logic                w_match;

  assign w_match = (fire_in == r_target[r_idx]);

  // Whole controller in one sequential block: every output is registered,
  // so the neuron inputs never glitch and hold their last value in IDLE.
  // done is raised while leaving DONE, so it appears one cycle after the
  // last CHECK and lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_target     <= '0;
      r_idx        <= '0;
      r_thresh     <= '0;
      r_settle     <= '0;
      r_x          <= 1'b0;
      r_y          <= 1'b0;
      r_thresh_out <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
      r_learned    <= '0;
      r_attempts   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_target   <= target;
            r_thresh   <= '0;
            r_idx      <= '0;
            r_attempts <= '0;
            r_found    <= 1'b0;
            r_learned  <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_x          <= r_idx[1];
          r_y          <= r_idx[0];
          r_thresh_out <= r_thresh;
          r_settle     <= '0;
          r_state      <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          if (r_settle == SETTLE_LAST) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            if (r_idx == 2'd3) begin
              r_found    <= 1'b1;
              r_learned  <= r_thresh;
              r_attempts <= r_attempts + 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= ST_DRIVE;
            end
          end else begin
            // A single mismatch rules out this threshold; the maximum
            // threshold is the last one tried, never wrapping to 0.
            r_attempts <= r_attempts + 1'b1;
            if (r_thresh == THRESH_MAX) begin
              r_found <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_thresh <= r_thresh + 1'b1;
              r_idx    <= '0;
              r_state  <= ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign x_out          = r_x;
  assign y_out          = r_y;
  assign thresh_out     = r_thresh_out;
  assign busy           = r_busy;
  assign done           = r_done;
  assign found          = r_found;
  assign learned_thresh = r_learned;
  assign attempts       = r_attempts;

endmodule

// File: tb/tb_mcp_threshold_trainer.sv
// -----------------------------------------------------------------------------
// tb_mcp_threshold_trainer
//   Closed-loop bench: trainer drives a neuronode, neuronode fire feeds back.
//   Directed truth tables with hand-computed results and done timing.
// -----------------------------------------------------------------------------
module tb_mcp_threshold_trainer;
  import mcp_pkg::*;

  localparam int THRESH_W      = 2;
  localparam int SETTLE_CYCLES = 2;
  localparam int TIMEOUT       = 200;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [3:0]          target;
  logic                x_out;
  logic                y_out;
  logic [THRESH_W-1:0] thresh_out;
  logic                fire;
  logic                busy;
  logic                done;
  logic                found;
  logic [THRESH_W-1:0] learned_thresh;
  logic [THRESH_W:0]   attempts;

  int n_compared;
  int n_mismatched;

  mcp_threshold_trainer #(
    .THRESH_W      (THRESH_W),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .target         (target),
    .x_out          (x_out),
    .y_out          (y_out),
    .thresh_out     (thresh_out),
    .fire_in        (fire),
    .busy           (busy),
    .done           (done),
    .found          (found),
    .learned_thresh (learned_thresh),
    .attempts       (attempts)
  );

  neuronode #(.THRESH_W(THRESH_W)) u_neuron (
    .x         (x_out),
    .y         (y_out),
    .Threshold (thresh_out),
    .fire      (fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs must be zero while in reset.
  task automatic check_all_zero(input string tag);
    n_compared++;
    if ({x_out, y_out, thresh_out, busy, done, found, learned_thresh, attempts} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL %s outputs: got x=%b y=%b th=%0d busy=%b done=%b found=%b lt=%0d att=%0d, want all 0",
               tag, x_out, y_out, thresh_out, busy, done, found, learned_thresh, attempts);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    target = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one training pass and checks result, timing and single done pulse.
  task automatic test_truth_table(input string name, input logic [3:0] tt,
                                  input logic exp_found, input logic [1:0] exp_lt,
                                  input logic [2:0] exp_att, input int exp_cycles);
    int cycles;
    int extra_done;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    target = tt;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cycles  = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cycles < TIMEOUT) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    n_compared++;
    if (!seen) begin
      n_mismatched++;
      $display("[TB] FAIL %s timeout: no done within %0d cycles", name, TIMEOUT);
    end
    n_compared++;
    if (cycles !== exp_cycles) begin
      n_mismatched++;
      $display("[TB] FAIL %s done_cycle: got %0d want %0d", name, cycles, exp_cycles);
    end
    n_compared++;
    if (!busy_ok || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL %s busy: run_ok=%b at_done=%b want run_ok=1 at_done=0", name, busy_ok, busy);
    end
    n_compared++;
    if (found !== exp_found) begin
      n_mismatched++;
      $display("[TB] FAIL %s found: got %b want %b", name, found, exp_found);
    end
    if (exp_found) begin
      n_compared++;
      if (learned_thresh !== exp_lt) begin
        n_mismatched++;
        $display("[TB] FAIL %s learned_thresh: got %0d want %0d", name, learned_thresh, exp_lt);
      end
    end
    n_compared++;
    if (attempts !== exp_att) begin
      n_mismatched++;
      $display("[TB] FAIL %s attempts: got %0d want %0d", name, attempts, exp_att);
    end
    extra_done = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra_done++;
    end
    n_compared++;
    if (extra_done !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s done_pulse: got %0d extra done cycles want 0", name, extra_done);
    end
  endtask

  // After AND (T=2) the last pattern driven is x=1,y=1,T=2 and must hold.
  task automatic test_hold_in_idle();
    repeat (3) @(posedge clk);
    #1;
    n_compared++;
    if (x_out !== 1'b1 || y_out !== 1'b1 || thresh_out !== 2'd2 || found !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL hold_idle: got x=%b y=%b th=%0d found=%b want x=1 y=1 th=2 found=1",
               x_out, y_out, thresh_out, found);
    end
  endtask

  // Extra start pulses while busy and in the DONE cycle, with a changed
  // target, must not disturb an AND run (7 patterns -> done at 29).
  task automatic test_back_to_back();
    int cycles;
    int done_count;
    int first_done;
    @(negedge clk);
    target = TT_AND;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    target     = TT_XOR;
    done_count = 0;
    first_done = -1;
    for (cycles = 1; cycles <= 40; cycles++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_count++;
        if (first_done < 0) first_done = cycles;
      end
      start = (cycles == 3 || cycles == 10 || cycles == 20 || cycles == 28);
    end
    start = 1'b0;
    n_compared++;
    if (first_done !== 29 || done_count !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_done: got first=%0d count=%0d want first=29 count=1", first_done, done_count);
    end
    n_compared++;
    if (found !== 1'b1 || learned_thresh !== 2'd2 || attempts !== 3'd3 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_result: got found=%b lt=%0d att=%0d busy=%b want 1/2/3/0",
               found, learned_thresh, attempts, busy);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    target = TT_AND;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_compared++;
    if (busy !== 1'b1 || thresh_out !== 2'd1) begin
      n_mismatched++;
      $display("[TB] FAIL midrun_pre: got busy=%b th=%0d want busy=1 th=1", busy, thresh_out);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_async");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_truth_table("one",  TT_ONE,  1'b1, 2'd0, 3'd1, 17);
    test_truth_table("or",   TT_OR,   1'b1, 2'd1, 3'd2, 21);
    test_truth_table("xor",  TT_XOR,  1'b0, 2'd0, 3'd4, 37);
    test_truth_table("zero", TT_ZERO, 1'b1, 2'd3, 3'd4, 45);
    test_truth_table("and",  TT_AND,  1'b1, 2'd2, 3'd3, 29);
    test_hold_in_idle();
    test_back_to_back();
    test_reset_midrun();
    test_truth_table("or_after_reset", TT_OR, 1'b1, 2'd1, 3'd2, 21);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
